// File: rtl/constraint_sample_ctrl_pkg.sv
// Shared types and constants for the constraint sampling controller.
// Holds the FSM state type and the LFSR polynomial plus its step function.
package constraint_sample_pkg;

  localparam int unsigned LFSR_W = 64;
  localparam logic [LFSR_W-1:0] LFSR_POLY = 64'hD800000000000000;
  // An all-zero Galois LFSR never leaves zero, so a zero seed is replaced by this value.
  localparam logic [LFSR_W-1:0] LFSR_SEED_ZERO_SUB = 64'h1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_CHECK,
    S_DRAIN,
    S_DONE,
    S_FAIL
  } state_t;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : '0);
  endfunction

endpackage

// File: rtl/constraint_sample_ctrl_if.sv
// Output stream of accepted candidates: valid/ready handshake with data.
interface constraint_sample_ctrl_if #(
  parameter int unsigned VEC_W = 1024
);
  logic             out_valid;
  logic             out_ready;
  logic [VEC_W-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/constraint_sample_ctrl_lfsr.sv
// 64-bit Galois LFSR with seed load and step enable; load has priority over step.
module sampler_lfsr64
  import constraint_sample_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [LFSR_W-1:0] seed_i,
  input  logic              step_i,
  output logic [LFSR_W-1:0] state_o
);

  logic [LFSR_W-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = (seed_i == '0) ? LFSR_SEED_ZERO_SUB : seed_i;
    end else if (step_i) begin
      state_d = lfsr_step(state_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LFSR_SEED_ZERO_SUB;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/constraint_sample_ctrl.sv
// Builds LFSR candidates chunk by chunk, samples the external checker and
// queues accepted candidates in a small output FIFO until the run ends.
module constraint_sample_ctrl
  import constraint_sample_pkg::*;
#(
  parameter int unsigned VEC_W       = 1024,
  parameter int unsigned NUM_SAMPLES = 16,
  parameter int unsigned MAX_TRIES   = 4096,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             seed_valid,
  input  logic [LFSR_W-1:0]                seed,
  output logic [VEC_W-1:0]                 cand,
  input  logic                             sat,
  constraint_sample_ctrl_if.master         out_if,
  output logic                             busy,
  output logic                             done,
  output logic                             fail,
  output logic [$clog2(NUM_SAMPLES+1)-1:0] accept_cnt
);

  localparam int unsigned CHUNKS = VEC_W / LFSR_W;
  localparam int unsigned ACC_W  = $clog2(NUM_SAMPLES + 1);
  localparam int unsigned TRY_W  = $clog2(MAX_TRIES + 1);
  localparam int unsigned CHK_W  = $clog2(CHUNKS + 1);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

  state_t            state_q, state_d;
  logic [VEC_W-1:0]  cand_q, cand_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [TRY_W-1:0]  try_q, try_d;
  logic [CHK_W-1:0]  chunk_q, chunk_d;
  logic              done_q, done_d, fail_q, fail_d;

  logic [VEC_W-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_q, rd_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              idle_like, lfsr_load, push, pop, full;
  logic [LFSR_W-1:0] lfsr_q;

  assign idle_like = state_q inside {S_IDLE, S_DONE, S_FAIL};
  assign lfsr_load = idle_like && seed_valid;

  sampler_lfsr64 u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load_i  (lfsr_load),
    .seed_i  (seed),
    .step_i  (state_q == S_FILL),
    .state_o (lfsr_q)
  );

  // A pop in the same cycle frees a slot, so a full FIFO can still take the push.
  assign full = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign pop  = out_if.out_valid && out_if.out_ready;
  assign push = (state_q == S_CHECK) && sat && (!full || pop);

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    acc_d   = acc_q;
    try_d   = try_q;
    chunk_d = chunk_q;
    done_d  = done_q;
    fail_d  = fail_q;
    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (state_q == S_DONE) done_d = 1'b1;
        if (state_q == S_FAIL) fail_d = 1'b1;
        if (start) begin
          state_d = S_FILL;
          acc_d   = '0;
          try_d   = '0;
          chunk_d = '0;
          done_d  = 1'b0;
          fail_d  = 1'b0;
        end
      end
      S_FILL: begin
        cand_d = (cand_q << LFSR_W) | VEC_W'(lfsr_step(lfsr_q));
        if (chunk_q == CHK_W'(CHUNKS - 1)) begin
          chunk_d = '0;
          state_d = S_CHECK;
        end else begin
          chunk_d = chunk_q + 1'b1;
        end
      end
      S_CHECK: begin
        if (sat) begin
          if (push) begin
            acc_d   = acc_q + 1'b1;
            try_d   = '0;
            state_d = (acc_d == ACC_W'(NUM_SAMPLES)) ? S_DRAIN : S_FILL;
          end
        end else begin
          try_d   = try_q + 1'b1;
          state_d = (try_d == TRY_W'(MAX_TRIES)) ? S_FAIL : S_FILL;
        end
      end
      S_DRAIN: begin
        // Leave as soon as the FIFO will be empty after this edge.
        if (cnt_d == '0) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cand_q  <= '0;
      acc_q   <= '0;
      try_q   <= '0;
      chunk_q <= '0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      acc_q   <= acc_d;
      try_q   <= try_d;
      chunk_q <= chunk_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      cnt_q   <= cnt_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= cand_q;
  end

  assign out_if.out_valid = (cnt_q != '0);
  assign out_if.out_data  = out_if.out_valid ? mem[rd_q] : '0;

  assign cand       = cand_q;
  assign busy       = !idle_like;
  assign done       = done_q;
  assign fail       = fail_q;
  assign accept_cnt = acc_q;

endmodule
